// File: rtl/ddr_wsvc.sv
// ddr_wsvc: two-channel toggle-handshake write arbiter issuing 64-bit Avalon-MM burst writes.
// Fixed priority to ch0; one outstanding request per channel, completion by ack toggle.
module ddr_wsvc (
   input  logic        clk,
   input  logic        reset,
   input  logic        ram_waitrequest,
   output logic [7:0]  ram_burstcnt,
   output logic [28:0] ram_addr,
   output logic [63:0] ram_writedata,
   output logic [7:0]  ram_byteenable,
   output logic        ram_write,
   output logic        ram_read,
   input  logic [28:0] ch0_addr,
   input  logic [7:0]  ch0_burst,
   input  logic [63:0] ch0_data,
   input  logic [7:0]  ch0_be,
   input  logic        ch0_req,
   output logic        ch0_ack,
   output logic        ch0_data_rd,
   input  logic [28:0] ch1_addr,
   input  logic [7:0]  ch1_burst,
   input  logic [63:0] ch1_data,
   input  logic [7:0]  ch1_be,
   input  logic        ch1_req,
   output logic        ch1_ack,
   output logic        ch1_data_rd,
   output logic        busy
);
   typedef enum logic {IDLE, WRITE} state_t;
   state_t      state_q;
   logic        ch_q;
   logic [7:0]  rem_q;
   logic [1:0]  ack_q;
   logic [1:0]  pend;
   logic        sel, grant, accept, step, sel_req;
   logic [7:0]  sel_burst, sel_be;
   logic [28:0] sel_addr;
   logic [63:0] sel_data;
   assign pend      = {ch1_req ^ ack_q[1], ch0_req ^ ack_q[0]};
   // In IDLE the arbiter picks ch0 whenever it is pending; during a burst the owner stays selected.
   assign sel       = (state_q == WRITE) ? ch_q : ~pend[0];
   assign grant     = (state_q == IDLE) && (pend != 2'b00);
   assign accept    = ram_write && !ram_waitrequest;
   assign sel_burst = sel ? ch1_burst : ch0_burst;
   assign sel_addr  = sel ? ch1_addr : ch0_addr;
   assign sel_data  = sel ? ch1_data : ch0_data;
   assign sel_be    = sel ? ch1_be : ch0_be;
   assign sel_req   = sel ? ch1_req : ch0_req;
   assign step      = !reset && (grant ? (sel_burst != 8'd0) : (accept && rem_q != 8'd0));
   assign ch0_data_rd = step && !sel;
   assign ch1_data_rd = step && sel;
   assign ch0_ack   = ack_q[0];
   assign ch1_ack   = ack_q[1];
   assign busy      = (state_q == WRITE);
   assign ram_read  = 1'b0;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         ch_q           <= 1'b0;
         rem_q          <= 8'd0;
         ack_q          <= 2'b00;
         ram_write      <= 1'b0;
         ram_burstcnt   <= 8'd0;
         ram_addr       <= 29'd0;
         ram_writedata  <= 64'd0;
         ram_byteenable <= 8'd0;
      end else if (grant) begin
         ch_q <= sel;
         if (sel_burst == 8'd0) begin
            ack_q[sel] <= sel_req;
         end else begin
            state_q        <= WRITE;
            ram_write      <= 1'b1;
            ram_addr       <= sel_addr;
            ram_burstcnt   <= sel_burst;
            ram_writedata  <= sel_data;
            ram_byteenable <= sel_be;
            rem_q          <= sel_burst - 8'd1;
         end
      end else if (accept) begin
         if (rem_q != 8'd0) begin
            ram_writedata  <= sel_data;
            ram_byteenable <= sel_be;
            rem_q          <= rem_q - 8'd1;
         end else begin
            ram_write  <= 1'b0;
            state_q    <= IDLE;
            ack_q[ch_q] <= sel_req;
         end
      end
   end
endmodule

// File: tb/tb_ddr_wsvc.sv
// tb_ddr_wsvc: directed bench for ddr_wsvc with a beat scoreboard fed by modelled show-ahead clients.
// Inputs change 1 time unit after the rising edge; the scoreboard samples on the falling edge.
module tb_ddr_wsvc;
   logic        clk = 1'b0, reset = 1'b1, ram_waitrequest = 1'b0;
   logic [7:0]  ram_burstcnt, ram_byteenable;
   logic [28:0] ram_addr;
   logic [63:0] ram_writedata;
   logic        ram_write, ram_read, busy;
   logic [28:0] ch0_addr = '0, ch1_addr = '0;
   logic [7:0]  ch0_burst = '0, ch1_burst = '0, ch0_be, ch1_be;
   logic [63:0] ch0_data, ch1_data;
   logic        ch0_req = 1'b0, ch1_req = 1'b0;
   logic        ch0_ack, ch1_ack, ch0_data_rd, ch1_data_rd;
   int checks = 0, failures = 0;
   typedef struct {
      int          ch;
      logic [28:0] addr;
      logic [7:0]  burst;
      logic [63:0] data;
      logic [7:0]  be;
      logic        ackv;
      logic        last;
   } beat_t;
   beat_t q[$];
   beat_t e;
   logic [63:0] dm [2][4096];
   logic [7:0]  bm [2][4096];
   int ptr [2] = '{0, 0};
   int rd_cnt [2] = '{0, 0};
   int exp_rd [2] = '{0, 0};
   logic [1:0] ack_due = 2'b00;
   logic ack_exp [2];
   always #5 clk = ~clk;
   ddr_wsvc dut (
      .clk(clk), .reset(reset), .ram_waitrequest(ram_waitrequest),
      .ram_burstcnt(ram_burstcnt), .ram_addr(ram_addr), .ram_writedata(ram_writedata),
      .ram_byteenable(ram_byteenable), .ram_write(ram_write), .ram_read(ram_read),
      .ch0_addr(ch0_addr), .ch0_burst(ch0_burst), .ch0_data(ch0_data), .ch0_be(ch0_be),
      .ch0_req(ch0_req), .ch0_ack(ch0_ack), .ch0_data_rd(ch0_data_rd),
      .ch1_addr(ch1_addr), .ch1_burst(ch1_burst), .ch1_data(ch1_data), .ch1_be(ch1_be),
      .ch1_req(ch1_req), .ch1_ack(ch1_ack), .ch1_data_rd(ch1_data_rd),
      .busy(busy)
   );
   // Show-ahead clients: current beat is always visible, advance after each data_rd edge.
   assign ch0_data = dm[0][ptr[0]];
   assign ch0_be   = bm[0][ptr[0]];
   assign ch1_data = dm[1][ptr[1]];
   assign ch1_be   = bm[1][ptr[1]];
   always @(posedge clk) begin
      if (ch0_data_rd) ptr[0] <= ptr[0] + 1;
      if (ch1_data_rd) ptr[1] <= ptr[1] + 1;
   end
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic issue(input int c, input logic [28:0] a, input int n, input logic [63:0] base,
                        input logic [7:0] be0, input logic [7:0] be1);
      beat_t b;
      logic nr;
      nr = c ? ~ch1_req : ~ch0_req;
      for (int i = 0; i < n; i++) begin
         dm[c][ptr[c] + i] = base + 64'(i);
         bm[c][ptr[c] + i] = i[0] ? be1 : be0;
         b.ch = c; b.addr = a; b.burst = n[7:0]; b.data = base + 64'(i);
         b.be = i[0] ? be1 : be0; b.ackv = nr; b.last = (i == n - 1);
         q.push_back(b);
      end
      exp_rd[c] += n;
      if (c == 0) begin ch0_addr = a; ch0_burst = n[7:0]; ch0_req = nr; end
      else begin ch1_addr = a; ch1_burst = n[7:0]; ch1_req = nr; end
   endtask
   // Scoreboard: every accepted beat must be the next expected beat of the expected request.
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         ack_due = 2'b00;
      end else begin
         for (int c = 0; c < 2; c++)
            if (ack_due[c]) begin
               chk("ack_after_last", c ? ch1_ack : ch0_ack, ack_exp[c]);
               ack_due[c] = 1'b0;
            end
         chk("ram_read", ram_read, 0);
         chk("busy_vs_write", busy, ram_write);
         if (ram_write && ram_waitrequest) chk("rd_during_stall", {ch1_data_rd, ch0_data_rd}, 0);
         if (ram_write && !ram_waitrequest) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat data=%h at %0t", ram_writedata, $time);
            end else begin
               e = q.pop_front();
               chk("beat_addr", ram_addr, e.addr);
               chk("beat_burstcnt", ram_burstcnt, e.burst);
               chk("beat_data", ram_writedata, e.data);
               chk("beat_be", ram_byteenable, e.be);
               if (e.last) begin
                  ack_due[e.ch] = 1'b1;
                  ack_exp[e.ch] = e.ackv;
               end
            end
         end
         rd_cnt[0] += int'(ch0_data_rd);
         rd_cnt[1] += int'(ch1_data_rd);
      end
   end
   initial begin
      int n;
      tick(3);
      chk("rst_write", ram_write, 0);
      chk("rst_burstcnt", ram_burstcnt, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_wdata", ram_writedata, 0);
      chk("rst_be", ram_byteenable, 0);
      chk("rst_acks", {ch1_ack, ch0_ack}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd", {ch1_data_rd, ch0_data_rd}, 0);
      reset = 1'b0;
      tick();
      // Basic 4-beat burst on ch0
      issue(0, 29'h100, 4, 64'd1, 8'hFF, 8'hFF);
      #1 chk("t1_rd_on_grant", ch0_data_rd, 1);
      tick();
      chk("t1_write", ram_write, 1);
      chk("t1_addr", ram_addr, 29'h100);
      chk("t1_burst", ram_burstcnt, 8'd4);
      chk("t1_busy", busy, 1);
      chk("t1_beat1", ram_writedata, 64'd1);
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk("t1_beat", ram_writedata, 64'(k));
         chk("t1_addr_held", ram_addr, 29'h100);
         chk("t1_ack_not_yet", ch0_ack, 0);
      end
      tick();
      chk("t1_write_done", ram_write, 0);
      chk("t1_ack", ch0_ack, 1);
      chk("t1_busy_done", busy, 0);
      chk("t1_rd_count", rd_cnt[0], 4);
      // ch1 burst 3 with a 2-cycle stall on beat 2
      issue(1, 29'h2000, 3, 64'hA0, 8'hFF, 8'hFF);
      tick(2);
      ram_waitrequest = 1'b1;
      #1 chk("t2_no_rd_stall", ch1_data_rd, 0);
      tick();
      chk("t2_hold_data", ram_writedata, 64'hA1);
      chk("t2_hold_write", ram_write, 1);
      tick();
      chk("t2_hold_data2", ram_writedata, 64'hA1);
      ram_waitrequest = 1'b0;
      tick();
      chk("t2_beat3", ram_writedata, 64'hA2);
      tick();
      chk("t2_done", ram_write, 0);
      chk("t2_ack", ch1_ack, 1);
      // Simultaneous requests: ch0 first, one IDLE cycle, then ch1
      issue(0, 29'h300, 2, 64'hB0, 8'hFF, 8'hFF);
      issue(1, 29'h400, 2, 64'hC0, 8'hFF, 8'hFF);
      tick();
      chk("t3_ch0_addr", ram_addr, 29'h300);
      chk("t3_ch0_b0", ram_writedata, 64'hB0);
      tick();
      chk("t3_ch0_b1", ram_writedata, 64'hB1);
      tick();
      chk("t3_idle_gap", ram_write, 0);
      chk("t3_ack0", ch0_ack, 0);
      chk("t3_ack1_pending", ch1_ack, 1);
      tick();
      chk("t3_ch1_write", ram_write, 1);
      chk("t3_ch1_addr", ram_addr, 29'h400);
      chk("t3_ch1_b0", ram_writedata, 64'hC0);
      tick(2);
      chk("t3_ack1", ch1_ack, 0);
      // Single-beat and zero-beat requests
      issue(0, 29'h500, 1, 64'hD0, 8'h3C, 8'h3C);
      #1 chk("t4_rd_grant", ch0_data_rd, 1);
      tick();
      chk("t4_single", ram_writedata, 64'hD0);
      chk("t4_single_be", ram_byteenable, 8'h3C);
      chk("t4_no_rd_last", ch0_data_rd, 0);
      tick();
      chk("t4_single_done", ram_write, 0);
      chk("t4_single_ack", ch0_ack, 1);
      issue(1, 29'h600, 0, 64'h0, 8'h00, 8'h00);
      #1 chk("t4_zero_no_rd", ch1_data_rd, 0);
      tick();
      chk("t4_zero_no_write", ram_write, 0);
      chk("t4_zero_ack", ch1_ack, 1);
      chk("t4_zero_busy", busy, 0);
      // Reset during beat 3 of an 8-beat burst
      issue(0, 29'h700, 8, 64'hE0, 8'hFF, 8'hFF);
      tick(3);
      chk("t5_beat3", ram_writedata, 64'hE2);
      reset = 1'b1;
      ch0_req = 1'b0;
      ch1_req = 1'b0;
      exp_rd[0] -= 5;
      tick();
      chk("t5_write_off", ram_write, 0);
      chk("t5_acks", {ch1_ack, ch0_ack}, 0);
      chk("t5_busy", busy, 0);
      chk("t5_rd", {ch1_data_rd, ch0_data_rd}, 0);
      reset = 1'b0;
      tick();
      issue(0, 29'h710, 2, 64'hF0, 8'hFF, 8'hFF);
      tick();
      chk("t5_after_addr", ram_addr, 29'h710);
      chk("t5_after_b0", ram_writedata, 64'hF0);
      tick(2);
      chk("t5_after_ack", ch0_ack, 1);
      // Byte enables follow each beat
      issue(1, 29'h800, 2, 64'h11, 8'h0F, 8'hF0);
      tick();
      chk("t6_be0", ram_byteenable, 8'h0F);
      tick();
      chk("t6_be1", ram_byteenable, 8'hF0);
      chk("t6_data1", ram_writedata, 64'h12);
      tick();
      chk("t6_ack", ch1_ack, 1);
      // Maximum burst with periodic stalls
      issue(0, 29'h1000, 255, 64'h1000, 8'hAA, 8'h55);
      tick();
      chk("t7_burstcnt", ram_burstcnt, 8'd255);
      n = 0;
      while (ch0_ack !== ch0_req && n < 400) begin
         ram_waitrequest = (n % 5 == 2);
         tick();
         n++;
      end
      ram_waitrequest = 1'b0;
      chk("t7_done", ch0_ack, ch0_req);
      tick(2);
      chk("rd_count_ch0", rd_cnt[0], exp_rd[0]);
      chk("rd_count_ch1", rd_cnt[1], exp_rd[1]);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
